// File: rtl/hilo_muldiv_unit.sv
// Execute-stage iterative multiply/divide engine owning the HI/LO register pair.
// One radix-2 step per cycle; results are committed to HI/LO one cycle after the last step.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic             multordivE,
  input  logic             signedE,
  input  logic             abortE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PRD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [PRD_W-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes: a WIDTH-bit negate of the most-negative value yields its exact unsigned magnitude
  assign a_neg = signedE & srcaE[WIDTH-1];
  assign b_neg = signedE & srcbE[WIDTH-1];
  assign a_abs = a_neg ? (~srcaE + WIDTH'(1)) : srcaE;
  assign b_abs = b_neg ? (~srcbE + WIDTH'(1)) : srcbE;

  // Shift-add multiply step (multiplier lives in quo_q) and restoring divide step (dividend lives in quo_q)
  assign mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  // Sign fix-up applied at commit
  assign prod     = {acc_q, quo_q};
  assign prod_fix = neg_res_q ? (~prod + PRD_W'(1)) : prod;
  assign quo_fix  = neg_res_q ? (~quo_q + WIDTH'(1)) : quo_q;
  assign rem_fix  = neg_rem_q ? (~acc_q + WIDTH'(1)) : acc_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (startE && !abortE) state_d = S_CALC;
      end
      S_CALC: begin
        if (abortE)             state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs; an abort in the commit cycle suppresses done
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state_q != S_IDLE);
    done = (state_q == S_COMMIT) && !abortE;
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    opb_d     = opb_q;
    opa_d     = opa_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (startE && !abortE) begin
          cnt_d     = CNT_W'(WIDTH - 1);
          acc_d     = '0;
          quo_d     = a_abs;
          opb_d     = b_abs;
          opa_d     = srcaE;
          div_d     = multordivE;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
        end
      end
      S_CALC: begin
        if (!abortE) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_d = div_diff[WIDTH-1:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[WIDTH-2:0], quo_q[WIDTH-1]};
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
          end
        end
      end
      S_COMMIT: begin
        if (!abortE) begin
          if (!div_q) begin
            hi_d = prod_fix[PRD_W-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (opb_q == '0) begin
            // Divide by zero: no trap, dividend passes through to HI
            hi_d = opa_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      opb_q     <= '0;
      opa_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      opb_q     <= opb_d;
      opa_q     <= opa_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
